// File: rtl/tt_um_ole_moller_7_segment_to_priority_decoder.sv
// 7-segment + dp receiver: sync, glitch filter, decode back to priority index.
// Drives one-hot index, code, status flags, update strobe and sticky error.
module tt_um_ole_moller_7_segment_to_priority_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } state_t;

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);
  localparam bit ONE_SHOT = (STABLE_CYCLES == 1);

  state_t     state;
  logic [7:0] s1;
  logic [7:0] s2;
  logic [7:0] cand;
  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  logic [7:0] acc_word;
  logic       acc_pulse;
  logic       acc_new;

  logic [7:0] uo_q;
  logic [2:0] code_q;
  logic       valid_q;
  logic       empty_q;
  logic       err_q;
  logic       strobe_q;
  logic       sticky_q;

  logic       start_new;
  logic       accept;

  logic       d_valid;
  logic       d_empty;
  logic       d_err;
  logic [2:0] d_code;

  wire unused = &{1'b0, ena, uio_in};

  assign cnt_inc = cnt + 4'd1;

  always_comb begin
    start_new = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE:   start_new = 1'b1;
      SETTLE: start_new = (s2 != cand);
      LOCKED: start_new = (s2 != acc_word);
      default: start_new = 1'b1;
    endcase
    if (start_new)
      accept = ONE_SHOT;
    else
      accept = (state == SETTLE) && (cnt_inc == STABLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      cand      <= '0;
      cnt       <= '0;
      acc_word  <= '0;
      acc_pulse <= 1'b0;
      acc_new   <= 1'b0;
      state     <= IDLE;
    end else begin
      s1        <= ui_in;
      s2        <= s1;
      acc_pulse <= 1'b0;
      if (accept) begin
        // A re-accepted word that is already on the outputs is not news.
        acc_word  <= s2;
        acc_pulse <= 1'b1;
        acc_new   <= (s2 != acc_word);
        cand      <= s2;
        cnt       <= '0;
        state     <= LOCKED;
      end else if (start_new) begin
        cand  <= s2;
        cnt   <= 4'd1;
        state <= SETTLE;
      end else if (state == SETTLE) begin
        cnt <= cnt_inc;
      end
    end
  end

  always_comb begin
    d_valid = 1'b0;
    d_empty = 1'b0;
    d_err   = 1'b0;
    d_code  = 3'd0;
    unique case (1'b1)
      (acc_word == 8'h80):                 d_empty = 1'b1;
      (acc_word[7] && acc_word[6:0] != 0): d_err = 1'b1;
      (acc_word == 8'h00):                 ;
      default: begin
        d_valid = 1'b1;
        unique case (acc_word[6:0])
          7'h3F: d_code = 3'd0;
          7'h06: d_code = 3'd1;
          7'h5B: d_code = 3'd2;
          7'h4F: d_code = 3'd3;
          7'h66: d_code = 3'd4;
          7'h6D: d_code = 3'd5;
          7'h7D: d_code = 3'd6;
          7'h07: d_code = 3'd7;
          default: begin
            d_valid = 1'b0;
            d_err   = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_q     <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      empty_q  <= 1'b0;
      err_q    <= 1'b0;
      strobe_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (acc_pulse) begin
        uo_q     <= d_valid ? (8'd1 << d_code) : 8'd0;
        code_q   <= d_code;
        valid_q  <= d_valid;
        empty_q  <= d_empty;
        err_q    <= d_err;
        strobe_q <= acc_new;
        sticky_q <= sticky_q | d_err;
      end
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {sticky_q, strobe_q, err_q, empty_q, valid_q, code_q};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_ole_moller_7_segment_to_priority_decoder.sv
// Directed bench for the 7-segment priority decoder.
// Table-driven word sweep plus glitch and mid-settle reset sequences.
module tb_tt_um_ole_moller_7_segment_to_priority_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] w;
    logic [7:0] uo;
    logic [7:0] uio;
  } vec_t;

  vec_t vecs[12];

  tt_um_ole_moller_7_segment_to_priority_decoder #(
    .STABLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .ui_in(ui_in),
    .uio_in(uio_in),
    .uo_out(uo_out),
    .uio_out(uio_out),
    .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  // Apply a word before the next edge k; outputs change after edge k+6.
  task automatic apply_word(input logic [7:0] w, input logic [7:0] exp_uo,
                            input logic [7:0] exp_uio,
                            input logic [7:0] prev_uo);
    ui_in = w;
    repeat (6) tick();
    check($sformatf("pre_uo_%02h", w), uo_out, prev_uo);
    tick();
    check($sformatf("uo_%02h", w), uo_out, exp_uo);
    check($sformatf("uio_%02h", w), uio_out, exp_uio);
    tick();
    check($sformatf("uio_hold_%02h", w), uio_out, exp_uio & 8'hBF);
    check($sformatf("uo_hold_%02h", w), uo_out, exp_uo);
  endtask

  initial begin
    vecs[0]  = '{8'h80, 8'h00, 8'h50};
    vecs[1]  = '{8'h87, 8'h00, 8'hE0};
    vecs[2]  = '{8'h7D, 8'h40, 8'hCE};
    vecs[3]  = '{8'h3F, 8'h01, 8'hC8};
    vecs[4]  = '{8'h06, 8'h02, 8'hC9};
    vecs[5]  = '{8'h5B, 8'h04, 8'hCA};
    vecs[6]  = '{8'h4F, 8'h08, 8'hCB};
    vecs[7]  = '{8'h66, 8'h10, 8'hCC};
    vecs[8]  = '{8'h6D, 8'h20, 8'hCD};
    vecs[9]  = '{8'h7D, 8'h40, 8'hCE};
    vecs[10] = '{8'h07, 8'h80, 8'hCF};
    vecs[11] = '{8'h7F, 8'h00, 8'hE0};

    rst_n  = 1'b0;
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h00;
    repeat (2) tick();
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'hFF);

    rst_n = 1'b1;
    apply_word(8'h5B, 8'h04, 8'h4A, 8'h00);

    // Short excursion to 0x07 must not disturb the held 0x5B.
    ui_in = 8'h07;
    repeat (3) tick();
    ui_in = 8'h5B;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("glitch_uo", uo_out, 8'h04);
      check("glitch_uio", uio_out, 8'h0A);
    end

    for (int i = 0; i < 12; i++)
      apply_word(vecs[i].w, vecs[i].uo, vecs[i].uio,
                 (i == 0) ? 8'h04 : vecs[i-1].uo);

    apply_word(8'h00, 8'h00, 8'hC0, 8'h00);

    // Reset while the filter is part way through counting 0x3F.
    ui_in = 8'h3F;
    repeat (4) tick();
    check("pre_rst_uio", uio_out, 8'h80);
    rst_n = 1'b0;
    #1;
    check("async_rst_uo", uo_out, 8'h00);
    check("async_rst_uio", uio_out, 8'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("relat_pre_uo", uo_out, 8'h00);
    check("relat_pre_uio", uio_out, 8'h00);
    tick();
    check("relat_uo", uo_out, 8'h01);
    check("relat_uio", uio_out, 8'h48);
    tick();
    check("relat_hold_uio", uio_out, 8'h08);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
